// File: rtl/xadc_scan_ctrl.sv
// XADC DRP read sequencer: round-robin over VAUX6/7/14/15, one read per eoc.
// Optional XADC_SCAN_AVG_EN turns each channel register into a 1/4-weight IIR.
module xadc_scan_ctrl #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [6:0] ADDR_CH0       = 7'h16,
    parameter logic [6:0] ADDR_CH1       = 7'h17,
    parameter logic [6:0] ADDR_CH2       = 7'h1E,
    parameter logic [6:0] ADDR_CH3       = 7'h1F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    input  logic        drp_drdy,
    input  logic [15:0] drp_do,
    input  logic [1:0]  sel,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    output logic [11:0] ch0_data,
    output logic [11:0] ch1_data,
    output logic [11:0] ch2_data,
    output logic [11:0] ch3_data,
    output logic [11:0] sel_data,
    output logic [3:0]  ch_valid,
    output logic        upd,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        STORE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [1:0]     slot;
    logic           pending;
    logic [CW-1:0]  cnt;
    logic [11:0]    ch_q [4];
    logic [11:0]    sample;
    logic [11:0]    new_val;
    logic [6:0]     slot_addr;
    logic           tmo_hit;
    logic           got_data;
    logic           unused_lsb;

    assign unused_lsb = ^drp_do[3:0];
    assign sample     = drp_do[15:4];
    assign tmo_hit    = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign got_data   = (state == WAIT) && drp_drdy;

    assign ch0_data = ch_q[0];
    assign ch1_data = ch_q[1];
    assign ch2_data = ch_q[2];
    assign ch3_data = ch_q[3];

    always_comb begin
        slot_addr = ADDR_CH0;
        unique case (slot)
            2'd0: slot_addr = ADDR_CH0;
            2'd1: slot_addr = ADDR_CH1;
            2'd2: slot_addr = ADDR_CH2;
            2'd3: slot_addr = ADDR_CH3;
        endcase
    end

`ifdef XADC_SCAN_AVG_EN
    logic signed [13:0] diff;
    logic signed [13:0] step;
    logic signed [13:0] acc;

    // ch += (sample - ch) >>> 2, first good sample of a slot loads as-is
    always_comb begin
        diff    = $signed({2'b00, sample}) - $signed({2'b00, ch_q[slot]});
        step    = diff >>> 2;
        acc     = $signed({2'b00, ch_q[slot]}) + step;
        new_val = ch_valid[slot] ? acc[11:0] : sample;
    end
`else
    always_comb begin
        new_val = sample;
    end
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (eoc || pending) state_nx = REQ;
            REQ:     state_nx = WAIT;
            WAIT: begin
                if (drp_drdy)     state_nx = STORE;
                else if (tmo_hit) state_nx = IDLE;
            end
            STORE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= 2'd0;
            pending     <= 1'b0;
            cnt         <= '0;
            drp_den     <= 1'b0;
            drp_daddr   <= ADDR_CH0;
            upd         <= 1'b0;
            timeout_err <= 1'b0;
            ch_valid    <= 4'h0;
            sel_data    <= 12'h000;
            for (int i = 0; i < 4; i++) ch_q[i] <= 12'h000;
        end else begin
            state <= state_nx;

            // one-deep: eoc outside IDLE is remembered, extras collapse
            if (state == IDLE)
                pending <= 1'b0;
            else if (eoc)
                pending <= 1'b1;

            drp_den <= (state_nx == REQ);
            if (state_nx == REQ)
                drp_daddr <= slot_addr;

            if (state == REQ)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;

            upd <= got_data;
            if (got_data) begin
                ch_q[slot]     <= new_val;
                ch_valid[slot] <= 1'b1;
            end

            if (state == WAIT && !drp_drdy && tmo_hit) begin
                timeout_err <= 1'b1;
                slot        <= slot + 2'd1;
            end
            if (state == STORE)
                slot <= slot + 2'd1;

            sel_data <= ch_q[sel];
        end
    end

endmodule

// File: tb/tb_xadc_scan_ctrl.sv
// Directed bench for xadc_scan_ctrl: scan table, sel table, pending,
// timeout and mid-read reset sequences.
module tb_xadc_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        eoc;
    logic        drp_drdy;
    logic [15:0] drp_do;
    logic [1:0]  sel;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic [11:0] ch0_data;
    logic [11:0] ch1_data;
    logic [11:0] ch2_data;
    logic [11:0] ch3_data;
    logic [11:0] sel_data;
    logic [3:0]  ch_valid;
    logic        upd;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int den_cnt  = 0;
    int upd_cnt  = 0;

    typedef struct {
        logic [15:0] dv;
        logic [6:0]  addr;
        int          idx;
        logic [11:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [1:0]  s;
        logic [11:0] exp;
    } sel_vec_t;

    rd_vec_t  scan_tab [4];
    sel_vec_t sel_tab  [4];

    xadc_scan_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .eoc         (eoc),
        .drp_drdy    (drp_drdy),
        .drp_do      (drp_do),
        .sel         (sel),
        .drp_den     (drp_den),
        .drp_daddr   (drp_daddr),
        .ch0_data    (ch0_data),
        .ch1_data    (ch1_data),
        .ch2_data    (ch2_data),
        .ch3_data    (ch3_data),
        .sel_data    (sel_data),
        .ch_valid    (ch_valid),
        .upd         (upd),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drp_den) den_cnt++;
        if (upd)     upd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ch_of(input int i);
        case (i)
            0:       return ch0_data;
            1:       return ch1_data;
            2:       return ch2_data;
            default: return ch3_data;
        endcase
    endfunction

    task automatic do_read(input rd_vec_t v);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("den_rise", {31'd0, drp_den}, 32'd1);
        chk("daddr", {25'd0, drp_daddr}, {25'd0, v.addr});
        tick();
        chk("den_pulse", {31'd0, drp_den}, 32'd0);
        tick();
        tick();
        drp_do   = v.dv;
        drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        chk("upd_pulse", {31'd0, upd}, 32'd1);
        chk("ch_data", {20'd0, ch_of(v.idx)}, {20'd0, v.exp});
        tick();
        chk("upd_low", {31'd0, upd}, 32'd0);
    endtask

    initial begin
        int d0;
        int u0;
        rd_vec_t v;

        scan_tab[0] = '{16'h1230, 7'h16, 0, 12'h123};
        scan_tab[1] = '{16'h4560, 7'h17, 1, 12'h456};
        scan_tab[2] = '{16'h7890, 7'h1E, 2, 12'h789};
        scan_tab[3] = '{16'hABC0, 7'h1F, 3, 12'hABC};
        sel_tab[0]  = '{2'd2, 12'h789};
        sel_tab[1]  = '{2'd0, 12'h123};
        sel_tab[2]  = '{2'd1, 12'h456};
        sel_tab[3]  = '{2'd3, 12'hABC};

        rst      = 1'b1;
        eoc      = 1'b0;
        drp_drdy = 1'b0;
        drp_do   = 16'h0000;
        sel      = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_den", {31'd0, drp_den}, 32'd0);
        chk("rst_daddr", {25'd0, drp_daddr}, 32'h16);
        chk("rst_valid", {28'd0, ch_valid}, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        chk("rst_upd", {31'd0, upd}, 32'd0);
        chk("rst_sel", {20'd0, sel_data}, 32'd0);
        chk("rst_ch0", {20'd0, ch0_data}, 32'd0);

        // round-robin scan, eoc spaced ~100 cycles
        u0 = upd_cnt;
        for (int i = 0; i < 4; i++) begin
            do_read(scan_tab[i]);
            repeat (92) tick();
        end
        chk("scan_valid", {28'd0, ch_valid}, 32'hF);
        chk("scan_upd_cnt", upd_cnt - u0, 32'd4);

        for (int i = 0; i < 4; i++) begin
            sel = sel_tab[i].s;
            tick();
            chk("sel_data", {20'd0, sel_data}, {20'd0, sel_tab[i].exp});
        end

        // drdy never comes on slot 0
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("tmo_daddr", {25'd0, drp_daddr}, 32'h16);
        repeat (64) tick();
        chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("tmo_set", {31'd0, timeout_err}, 32'd1);
        chk("tmo_ch0", {20'd0, ch0_data}, 32'h123);
        chk("tmo_valid", {28'd0, ch_valid}, 32'hF);
        repeat (5) tick();
`ifdef XADC_SCAN_AVG_EN
        v = '{16'h4440, 7'h17, 1, 12'h451};
`else
        v = '{16'h4440, 7'h17, 1, 12'h444};
`endif
        do_read(v);
        chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
        repeat (5) tick();

        // two eoc during one read: one extra read, second eoc dropped
        d0 = den_cnt;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("pend_daddr0", {25'd0, drp_daddr}, 32'h1E);
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        drp_do   = 16'h2220;
        drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
`ifdef XADC_SCAN_AVG_EN
        chk("pend_ch2", {20'd0, ch2_data}, 32'h62F);
`else
        chk("pend_ch2", {20'd0, ch2_data}, 32'h222);
`endif
        tick();
        chk("pend_idle_den", {31'd0, drp_den}, 32'd0);
        tick();
        chk("pend_den", {31'd0, drp_den}, 32'd1);
        chk("pend_daddr1", {25'd0, drp_daddr}, 32'h1F);
        tick();
        tick();
        tick();
        drp_do   = 16'h3330;
        drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
`ifdef XADC_SCAN_AVG_EN
        chk("pend_ch3", {20'd0, ch3_data}, 32'h8D9);
`else
        chk("pend_ch3", {20'd0, ch3_data}, 32'h333);
`endif
        repeat (20) tick();
        chk("pend_den_cnt", den_cnt - d0, 32'd2);

        // reset two cycles into WAIT, late drdy must be ignored
        do_read('{16'h1230, 7'h16, 0, 12'h123});
        repeat (3) tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        chk("mid_daddr", {25'd0, drp_daddr}, 32'h17);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u0 = upd_cnt;
        chk("mid_den", {31'd0, drp_den}, 32'd0);
        chk("mid_tmo", {31'd0, timeout_err}, 32'd0);
        drp_do   = 16'h5550;
        drp_drdy = 1'b1;
        tick();
        drp_drdy = 1'b0;
        tick();
        tick();
        chk("mid_upd", upd_cnt - u0, 32'd0);
        chk("mid_valid", {28'd0, ch_valid}, 32'd0);
        chk("mid_ch1", {20'd0, ch1_data}, 32'd0);

        // slot 0 gets 000 then 400
        do_read('{16'h0000, 7'h16, 0, 12'h000});
        do_read('{16'h0000, 7'h17, 1, 12'h000});
        do_read('{16'h0000, 7'h1E, 2, 12'h000});
        do_read('{16'h0000, 7'h1F, 3, 12'h000});
`ifdef XADC_SCAN_AVG_EN
        do_read('{16'h4000, 7'h16, 0, 12'h100});
`else
        do_read('{16'h4000, 7'h16, 0, 12'h400});
`endif
        chk("final_valid", {28'd0, ch_valid}, 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xadc_scan_ctrl.md
Name: xadc_scan_ctrl

Overview:
- Sequencer for the XADC DRP read port; replaces the switch-driven static channel address.
- Round-robins reads over the four auxiliary channels VAUX6, VAUX7, VAUX14 and VAUX15, one read per end-of-conversion event.
- Keeps a 12-bit result register per channel and exposes the channel picked by sw.
- Consumers (volume/soundtrack control, debug SSD) read stable per-channel values without driving DRP addressing themselves.

Parameters:
- TIMEOUT_CYCLES, 64: max clk cycles to wait for drdy after den before the read is aborted.
- ADDR_CH0, 7'h16: DRP address of slot 0 (VAUX6).
- ADDR_CH1, 7'h17: DRP address of slot 1 (VAUX7).
- ADDR_CH2, 7'h1E: DRP address of slot 2 (VAUX14).
- ADDR_CH3, 7'h1F: DRP address of slot 3 (VAUX15).

Ports:
- clk  in  1  system clock, 100 MHz; also drives the XADC dclk_in.
- rst  in  1  synchronous reset, active-high.
- eoc  in  1  XADC eoc_out; a one-cycle pulse per conversion.
- drp_drdy  in  1  XADC drdy_out.
- drp_do  in  16  XADC do_out; bits [15:4] are the 12-bit sample.
- sel  in  2  channel slot shown on sel_data.
- drp_den  out  1  DRP enable; one-cycle pulse.
- drp_daddr  out  7  DRP address.
- ch0_data  out  12  latest VAUX6 result.
- ch1_data  out  12  latest VAUX7 result.
- ch2_data  out  12  latest VAUX14 result.
- ch3_data  out  12  latest VAUX15 result.
- sel_data  out  12  registered copy of ch[sel]_data.
- ch_valid  out  4  per-slot flag, sticky: slot holds at least one good sample.
- upd  out  1  one-cycle pulse whenever any chN_data updates.
- timeout_err  out  1  sticky flag; set on any drdy timeout.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on clk.
- Reset values:
  - all chN_data = 0, sel_data = 0, ch_valid = 0.
  - drp_den = 0, drp_daddr = ADDR_CH0, upd = 0, timeout_err = 0.
  - slot pointer = 0, pending = 0, FSM = IDLE.
- FSM states: IDLE, REQ, WAIT, STORE.
  - IDLE: stays until eoc is high or pending = 1, then goes to REQ. Clears pending on leaving.
  - REQ: exactly one cycle. drp_den = 1; drp_daddr = address of the current slot. Loads the timeout counter with 0. Goes to WAIT.
  - WAIT: drp_den = 0.
    - If drp_drdy: capture drp_do[15:4], go to STORE.
    - Else if counter = TIMEOUT_CYCLES-1: set timeout_err, advance the slot, go to IDLE. Data and ch_valid are unchanged.
    - Otherwise increment the counter.
  - STORE: write the captured sample to ch[slot]_data, set ch_valid[slot], pulse upd for 1 cycle, advance the slot, go to IDLE.
- Slot pointer: 2-bit, advances 0→1→2→3→0 with natural wrap.
- drp_daddr holds its value outside REQ; it changes only when REQ is entered.
- eoc while not in IDLE sets pending. Pending is one deep: extra eoc pulses are dropped, never queued.
- eoc in the same cycle that WAIT→IDLE or STORE→IDLE happens also sets pending. The next read then starts one cycle after reaching IDLE.
- drp_drdy outside WAIT is ignored.
- Latency: eoc in IDLE at cycle n gives den at n+1. drdy at cycle m gives chN_data and upd at m+1, and sel_data at m+2.
- sel_data = ch[sel]_data, registered every cycle. A sel change shows on sel_data 1 cycle later.
- Reset asserted mid-read (REQ or WAIT): the FSM goes to IDLE with den = 0. A drdy arriving later is ignored.
- timeout_err clears only on rst.

Optional Feature:
- Macro: XADC_SCAN_AVG_EN.
- Defined:
  - Each channel register is a first-order IIR: ch += (sample - ch) >>> 2. Arithmetic is 14-bit signed; the result is truncated to 12 bits.
  - The first good sample of a slot (ch_valid bit 0) loads directly.
  - upd timing is unchanged.
- Undefined: each channel register takes the raw sample.

Test Plan:
- Reset, then 4 eoc pulses 100 cycles apart, drdy 3 cycles after each den, drp_do = 16'h1230, 16'h4560, 16'h7890, 16'hABC0 → daddr sequence 16,17,1E,1F; ch0..3 = 123, 456, 789, ABC; ch_valid = 4'hF; four upd pulses.
- eoc while WAIT, plus a second eoc in the same read → exactly one extra read; den rises 1 cycle after returning to IDLE; the second eoc is dropped.
- No drdy after den → after 64 WAIT cycles timeout_err = 1, ch0_data and ch_valid[0] unchanged, next eoc reads daddr 17.
- sel = 2 after the first scenario → sel_data = 789 one cycle later; change sel to 0 → 123 one cycle later.
- rst asserted 2 cycles into WAIT, drdy arrives after reset release → no upd, ch_valid = 0, next read uses daddr 16.
- With XADC_SCAN_AVG_EN: slot 0 gets 000 then 400 → ch0 = 000, then 100.
